reg_file_sb: RTL and testbench

- Parametrised successor to the 16x32 structural register file: generic depth and width, optional registered read ports, and same-cycle write-through bypass.
- Top address is the PC alias. Reads of it return pc_in + PC_OFFSET. Writes to it are redirected to the fetch stage as a registered one-cycle branch request.
- Adds a per-register pending-write scoreboard (busy bits) so the pipeline can stall on loads in flight.
- Sits between decode (read ports, busy set) and writeback (write port) of the CPU pipeline.

---
 rtl/reg_file_sb.sv | 129 ++++++++++++
 tb/tb_reg_file_sb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Parametrised register file with PC alias at the top address, write-through
// bypass, optional registered read ports and a pending-write scoreboard.

module reg_file_sb_rport #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int PC_OFFSET = 8
) (
    input  logic [ADDR_W-1:0]                    a,
    input  logic                                 we3,
    input  logic [ADDR_W-1:0]                    a3,
    input  logic [DATA_W-1:0]                    wd3,
    input  logic [DATA_W-1:0]                    pc_in,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   regs,
    input  logic [(2**ADDR_W)-1:0]               busy,
    output logic [DATA_W-1:0]                    data,
    output logic                                 valid
);
    localparam logic [ADDR_W-1:0] TOP = {ADDR_W{1'b1}};

    // PC alias beats bypass, bypass beats storage
    always_comb begin
        data  = regs[a];
        valid = !busy[a];
        if (a == TOP) begin
            data  = pc_in + DATA_W'(PC_OFFSET);
            valid = 1'b1;
        end else if (we3 && a3 == a) begin
            data  = wd3;
            valid = 1'b1;
        end
    end
endmodule

module reg_file_sb #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int PC_OFFSET = 8,
    parameter bit SYNC_READ = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd1_valid,
    output logic              rd2_valid,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wdata
);
    localparam int NUM_PORTS = 2;
    localparam int DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] TOP = {ADDR_W{1'b1}};

    logic [DEPTH-1:0][DATA_W-1:0]     regs;
    logic [DEPTH-1:0]                 busy;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data_c, data_q;
    logic [NUM_PORTS-1:0]             valid_c, valid_q;

    assign addr = {a2, a1};

    // The top entry is never stored; it only exists so reads index cleanly
    always_ff @(posedge clk) begin
        if (reset) begin
            regs     <= '0;
            busy     <= '0;
            pc_we    <= 1'b0;
            pc_wdata <= '0;
        end else begin
            pc_we <= 1'b0;
            if (we3) begin
                if (a3 == TOP) begin
                    pc_we    <= 1'b1;
                    pc_wdata <= wd3;
                end else begin
                    regs[a3] <= wd3;
                    busy[a3] <= 1'b0;
                end
            end
            // A new load supersedes a same-cycle writeback to that register
            if (busy_set && busy_addr != TOP)
                busy[busy_addr] <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        reg_file_sb_rport #(
            .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_OFFSET(PC_OFFSET)
        ) u_rport (
            .a     (addr[p]),
            .we3   (we3),
            .a3    (a3),
            .wd3   (wd3),
            .pc_in (pc_in),
            .regs  (regs),
            .busy  (busy),
            .data  (data_c[p]),
            .valid (valid_c[p])
        );

        if (SYNC_READ) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q[p]  <= '0;
                    valid_q[p] <= 1'b1;
                end else begin
                    data_q[p]  <= data_c[p];
                    valid_q[p] <= valid_c[p];
                end
            end
        end else begin : g_comb
            assign data_q[p]  = data_c[p];
            assign valid_q[p] = valid_c[p];
        end
    end

    assign rd1       = data_q[0];
    assign rd2       = data_q[1];
    assign rd1_valid = valid_q[0];
    assign rd2_valid = valid_q[1];
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: one combinational-read and one
// registered-read instance share stimulus; a monitor checks queued expectations.

module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        reset, we3, busy_set;
    logic [3:0]  a1, a2, a3, busy_addr;
    logic [31:0] wd3, pc_in;

    logic [31:0] rd1, rd2, pc_wdata, s_rd1, s_rd2, s_pc_wdata;
    logic        rd1_valid, rd2_valid, pc_we, s_rd1_valid, s_rd2_valid, s_pc_we;

    always #5 clk = ~clk;

    reg_file_sb #(.ADDR_W(4), .DATA_W(32), .PC_OFFSET(8), .SYNC_READ(1'b0)) u_comb (
        .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
        .pc_in(pc_in), .busy_set(busy_set), .busy_addr(busy_addr),
        .rd1(rd1), .rd2(rd2), .rd1_valid(rd1_valid), .rd2_valid(rd2_valid),
        .pc_we(pc_we), .pc_wdata(pc_wdata));

    reg_file_sb #(.ADDR_W(4), .DATA_W(32), .PC_OFFSET(8), .SYNC_READ(1'b1)) u_sync (
        .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
        .pc_in(pc_in), .busy_set(busy_set), .busy_addr(busy_addr),
        .rd1(s_rd1), .rd2(s_rd2), .rd1_valid(s_rd1_valid), .rd2_valid(s_rd2_valid),
        .pc_we(s_pc_we), .pc_wdata(s_pc_wdata));

    typedef enum int {RD1, RD2, V1, V2, PCWE, PCWD, S_RD1, S_V1, S_RD2, S_V2} sig_e;
    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(sig_e s);
        case (s)
            RD1:     return rd1;
            RD2:     return rd2;
            V1:      return {31'd0, rd1_valid};
            V2:      return {31'd0, rd2_valid};
            PCWE:    return {31'd0, pc_we};
            PCWD:    return pc_wdata;
            S_RD1:   return s_rd1;
            S_V1:    return {31'd0, s_rd1_valid};
            S_RD2:   return s_rd2;
            default: return {31'd0, s_rd2_valid};
        endcase
    endfunction

    task automatic expect_at(input int c, input sig_e s, input logic [31:0] v, input string n);
        chk_t e;
        e.cyc = c; e.sig = s; e.exp = v; e.name = n;
        q.push_back(e);
    endtask

    // Monitor: every falling edge, retire expectations due this cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            chk_t e;
            logic [31:0] act;
            e = q.pop_front();
            act = actual(e.sig);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", e.name, cyc, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we3 = 1'b0; busy_set = 1'b0; a3 = 4'd0; wd3 = '0; busy_addr = 4'd0;
    endtask

    initial begin
        reset = 1'b1; a1 = 4'd0; a2 = 4'd0; pc_in = 32'h0;
        idle();
        step(); step();

        // reset state, both ports
        reset = 1'b0; a1 = 4'd3; a2 = 4'd14;
        expect_at(cyc, RD1, 32'h0, "rst_rd1");
        expect_at(cyc, RD2, 32'h0, "rst_rd2");
        expect_at(cyc, V1, 32'h1, "rst_v1");
        expect_at(cyc, V2, 32'h1, "rst_v2");
        expect_at(cyc, PCWE, 32'h0, "rst_pcwe");
        expect_at(cyc, PCWD, 32'h0, "rst_pcwd");
        expect_at(cyc, S_RD1, 32'h0, "rst_srd1");
        expect_at(cyc, S_V1, 32'h1, "rst_sv1");

        // write-through bypass
        step();
        we3 = 1'b1; a3 = 4'd5; wd3 = 32'hDEADBEEF; a1 = 4'd5;
        expect_at(cyc, RD1, 32'hDEADBEEF, "bypass_rd1");
        expect_at(cyc, V1, 32'h1, "bypass_v1");
        expect_at(cyc + 1, S_RD1, 32'hDEADBEEF, "sync_bypass_rd1");

        step();
        idle(); a1 = 4'd5;
        expect_at(cyc, RD1, 32'hDEADBEEF, "stored_rd1");
        expect_at(cyc, V1, 32'h1, "nonbusy_write_v1");
        expect_at(cyc + 1, S_RD1, 32'hDEADBEEF, "sync_stored_rd1");

        // PC alias read, then PC write redirect
        step();
        pc_in = 32'h100; a2 = 4'd15;
        expect_at(cyc, RD2, 32'h108, "pc_rd2");
        expect_at(cyc, V2, 32'h1, "pc_v2");

        step();
        we3 = 1'b1; a3 = 4'd15; wd3 = 32'h200;
        expect_at(cyc, PCWE, 32'h0, "pcwe_before");
        expect_at(cyc, RD2, 32'h108, "pc_rd2_during_write");
        expect_at(cyc + 1, S_RD2, 32'h108, "sync_pc_rd2");

        step();
        idle(); a1 = 4'd15; pc_in = 32'h300;
        expect_at(cyc, PCWE, 32'h1, "pcwe_pulse");
        expect_at(cyc, PCWD, 32'h200, "pcwd");
        expect_at(cyc, RD1, 32'h308, "pc_tracks_rd1");

        // busy marking
        step();
        busy_set = 1'b1; busy_addr = 4'd7; a1 = 4'd7;
        expect_at(cyc, PCWE, 32'h0, "pcwe_drop");
        expect_at(cyc, V1, 32'h1, "busy_not_same_cycle");
        expect_at(cyc + 1, S_V1, 32'h1, "sync_busy_not_same_cycle");

        step();
        idle(); a1 = 4'd7;
        expect_at(cyc, V1, 32'h0, "busy_v1");
        expect_at(cyc, RD1, 32'h0, "busy_rd1");
        expect_at(cyc + 1, S_V1, 32'h0, "sync_busy_v1");

        step();
        we3 = 1'b1; a3 = 4'd7; wd3 = 32'h42; a1 = 4'd7;
        expect_at(cyc, RD1, 32'h42, "wb_bypass_rd1");
        expect_at(cyc, V1, 32'h1, "wb_bypass_v1");

        step();
        idle(); a1 = 4'd7;
        expect_at(cyc, RD1, 32'h42, "wb_rd1");
        expect_at(cyc, V1, 32'h1, "wb_cleared_v1");

        // set and write the same register: set wins
        step();
        busy_set = 1'b1; busy_addr = 4'd9; we3 = 1'b1; a3 = 4'd9; wd3 = 32'h11; a1 = 4'd9;
        expect_at(cyc, RD1, 32'h11, "setwr_bypass_rd1");
        expect_at(cyc, V1, 32'h1, "setwr_bypass_v1");

        step();
        idle(); a1 = 4'd9; a2 = 4'd9;
        expect_at(cyc, RD1, 32'h11, "setwr_rd1");
        expect_at(cyc, V1, 32'h0, "setwr_v1");
        expect_at(cyc, RD2, 32'h11, "same_addr_rd2");
        expect_at(cyc, V2, 32'h0, "same_addr_v2");

        // registered read latency, then reset mid-operation
        step();
        we3 = 1'b1; a3 = 4'd2; wd3 = 32'hA5; a1 = 4'd0; a2 = 4'd0;

        step();
        idle(); a1 = 4'd2;
        expect_at(cyc, S_RD1, 32'h0, "sync_latency_old");
        expect_at(cyc + 1, S_RD1, 32'hA5, "sync_latency_new");

        step();
        reset = 1'b1; we3 = 1'b1; a3 = 4'd15; wd3 = 32'h77;
        busy_set = 1'b1; busy_addr = 4'd4;

        step();
        reset = 1'b0; idle(); a1 = 4'd2; a2 = 4'd4;
        expect_at(cyc, S_RD1, 32'h0, "sync_reset_rd1");
        expect_at(cyc, S_V1, 32'h1, "sync_reset_v1");
        expect_at(cyc, RD1, 32'h0, "reset_reg2");
        expect_at(cyc, V2, 32'h1, "reset_overrides_busy");
        expect_at(cyc, PCWE, 32'h0, "reset_overrides_pcwe");
        expect_at(cyc, PCWD, 32'h0, "reset_pcwd");

        // PC-alias sum wraps to DATA_W
        step();
        pc_in = 32'hFFFFFFFC; a2 = 4'd15;
        expect_at(cyc, RD2, 32'h4, "pc_wrap_rd2");
        expect_at(cyc + 1, S_RD2, 32'h4, "sync_pc_wrap_rd2");

        step();
        idle();
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            $display("FAIL drain pending=%0d want=0", q.size());
            errors += q.size();
            checks += q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
